// File: rtl/spi_dc_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : spi_dc_rx_fifo
// Brief    : Edge-captured SPI word FIFO with D/C tag, registered output stage,
//            overflow flag and saturating drop counter.
// Revision : 1.0
// ============================================================================
module spi_dc_rx_fifo #(
    parameter int data_len = 8,
    parameter int depth    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     qvld,
    input  logic [data_len-1:0]      din,
    input  logic                     dc,
    input  logic                     clr,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [data_len-1:0]      m_data,
    output logic                     m_dc,
    output logic [$clog2(depth):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int                c_AW        = $clog2(depth);
    localparam int                c_EW        = data_len + 1;
    localparam logic [c_AW:0]     c_DEPTH     = (c_AW + 1)'(depth);
    localparam logic [0:0]        c_OUT_EMPTY = 1'b0;
    localparam logic [0:0]        c_OUT_FULL  = 1'b1;

    generate
        if (depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_depth
            $error("spi_dc_rx_fifo: depth must be a power of two, at least 2");
        end
    endgenerate

    logic                  r_qvld_d;
    logic [c_EW-1:0]       r_mem [depth];
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_AW:0]         r_count;
    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [data_len-1:0]   r_m_data;
    logic                  r_m_dc;
    logic                  r_overflow;
    logic [7:0]            r_drop_cnt;

    logic                  w_capture;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_write;
    logic                  w_drop;
    logic                  w_pop;

    assign w_full    = (r_count == c_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_capture = qvld & ~r_qvld_d & en;
    // Fullness is judged on the pre-edge count, so a same-cycle pop never rescues a word.
    assign w_write   = w_capture & ~w_full & ~clr;
    assign w_drop    = w_capture &  w_full & ~clr;

    // Edge detector keeps tracking through clr and en=0; reset parks it high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_qvld_d <= 1'b1;
        end else begin
            r_qvld_d <= qvld;
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= {dc, din};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state <= c_OUT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_OUT_EMPTY: if (!w_empty)            w_state_nxt = c_OUT_FULL;
            c_OUT_FULL:  if (m_ready && w_empty)  w_state_nxt = c_OUT_EMPTY;
            default:                              w_state_nxt = c_OUT_EMPTY;
        endcase
    end

    // A pop refills the output register; in OUT_FULL this happens on the accept edge.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            c_OUT_EMPTY: w_pop = ~w_empty;
            c_OUT_FULL:  w_pop = ~w_empty & m_ready;
            default:     w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_m_data <= '0;
            r_m_dc   <= 1'b0;
        end else if (w_pop) begin
            {r_m_dc, r_m_data} <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign m_valid  = (r_state == c_OUT_FULL);
    assign m_data   = r_m_data;
    assign m_dc     = r_m_dc;
    assign count    = r_count;
    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_spi_dc_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_dc_rx_fifo
// Brief    : Randomised scoreboard bench for spi_dc_rx_fifo with queue model.
// Revision : 1.0
// ============================================================================
module tb_spi_dc_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic                     clk = 1'b0;
    logic                     rst, en, qvld, dc, clr, m_ready;
    logic [DW-1:0]            din;
    logic                     m_valid, m_dc, full, empty, overflow;
    logic [DW-1:0]            m_data;
    logic [$clog2(DEPTH):0]   count;
    logic [7:0]               drop_cnt;

    spi_dc_rx_fifo #(.data_len(DW), .depth(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .qvld(qvld), .din(din), .dc(dc),
        .clr(clr), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_dc(m_dc), .count(count), .full(full), .empty(empty),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int beats = 0;
    bit chk_en = 1'b0;

    // Expected word stream (output slot first, then FIFO contents) and occupancy model.
    logic [DW:0] sb[$];
    int mf    = 0;
    bit mv    = 1'b0;
    bit mqd   = 1'b1;
    bit movf  = 1'b0;
    int mdrop = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        bit cap, refill, wr, pv;
        int pf;
        if (rst) begin
            sb.delete(); mf = 0; mv = 1'b0; mqd = 1'b1; movf = 1'b0; mdrop = 0;
        end else begin
            cap = qvld && !mqd && en;
            mqd = qvld;
            if (clr) begin
                sb.delete(); mf = 0; mv = 1'b0; movf = 1'b0; mdrop = 0;
            end else begin
                pf = mf;
                pv = mv;
                refill = (pf > 0) && (!pv || m_ready);
                mv = refill || (pv && !m_ready);
                wr = cap && (pf < DEPTH);
                mf = pf - int'(refill) + int'(wr);
                if (wr) begin
                    sb.push_back({dc, din});
                end else if (cap) begin
                    movf = 1'b1;
                    if (mdrop < 255) mdrop++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("occupancy", sb.size(), mf + int'(mv));
            check("m_valid", m_valid, mv);
            check("count", count, mf);
            check("full", full, mf == DEPTH);
            check("empty", empty, mf == 0);
            check("overflow", overflow, movf);
            check("drop_cnt", drop_cnt, mdrop);
            if (m_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    check("m_data", m_data, sb[0][DW-1:0]);
                    check("m_dc", m_dc, sb[0][DW]);
                    if (m_ready) begin
                        void'(sb.pop_front());
                        beats++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic f);
        din = d; dc = f; qvld = 1'b1;
        tick();
        qvld = 1'b0;
        tick();
    endtask

    task automatic drain();
        int n = 0;
        m_ready = 1'b1;
        while ((sb.size() != 0 || m_valid) && n < 400) begin
            tick();
            n++;
        end
        check("drain_timeout", n < 400, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int b0;
        rst = 1'b1; en = 1'b1; qvld = 1'b1; din = '0; dc = 1'b0; clr = 1'b0; m_ready = 1'b0;
        repeat (3) tick();
        chk_en = 1'b1;
        check("rst_m_data", m_data, 0);
        check("rst_m_dc", m_dc, 0);
        rst = 1'b0;
        // qvld already high at reset release must not be captured
        repeat (4) tick();
        check("rst_no_capture_cnt", count, 0);
        check("rst_no_capture_vld", m_valid, 0);
        qvld = 1'b0;
        tick();

        // Single word held high for 20 cycles: one beat, two-cycle latency
        m_ready = 1'b1; din = 8'hA5; dc = 1'b1; b0 = beats; qvld = 1'b1;
        tick();
        check("latency_k", m_valid, 0);
        tick();
        check("latency_k1", m_valid, 1);
        check("latency_data", m_data, 8'hA5);
        repeat (18) tick();
        qvld = 1'b0;
        repeat (3) tick();
        check("single_beat", beats - b0, 1);

        // Backpressure: output register holds word 0, FIFO holds 16 more, next one drops
        m_ready = 1'b0;
        for (int i = 0; i < 18; i++) send(8'(i), 1'b1);
        check("fill_count", count, 16);
        check("fill_full", full, 1);
        check("fill_ovf", overflow, 1);
        check("fill_drops", drop_cnt, 1);
        check("fill_head", m_data, 8'h00);
        b0 = beats;
        drain();
        check("fill_beats", beats - b0, 17);

        // clr with 7 buffered, overflow set, and a simultaneous capture
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'(8'h20 + i), 1'(i));
        check("clr_pre_count", count, 7);
        check("clr_pre_ovf", overflow, 1);
        clr = 1'b1; din = 8'h77; dc = 1'b1; qvld = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_count", count, 0);
        check("clr_valid", m_valid, 0);
        check("clr_ovf", overflow, 0);
        check("clr_drops", drop_cnt, 0);
        qvld = 1'b0;
        repeat (3) tick();
        check("clr_cap_discarded", count, 0);

        // Edge while en low, then en raised with qvld still high
        en = 1'b0; qvld = 1'b1; din = 8'h3C;
        repeat (2) tick();
        en = 1'b1;
        repeat (3) tick();
        qvld = 1'b0;
        tick();
        check("en_low_no_cap_cnt", count, 0);
        check("en_low_no_cap_vld", m_valid, 0);

        // Wrap-around with 50% consumer duty
        fork
            begin
                for (int i = 0; i < 40; i++) send(8'($urandom), 1'($urandom));
            end
            begin
                repeat (80) begin
                    m_ready = ~m_ready;
                    tick();
                end
            end
        join
        drain();
        check("wrap_no_drop", drop_cnt, 0);

        // Simultaneous push and pop at count 5
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(8'(8'h40 + i), 1'b0);
        check("pp_pre_count", count, 5);
        din = 8'h99; dc = 1'b1; qvld = 1'b1; m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("pp_count", count, 5);
        qvld = 1'b0;
        tick();
        drain();

        // Saturation: 300 drops while full
        m_ready = 1'b0;
        for (int i = 0; i < 17; i++) send(8'(8'h80 + i), 1'(i));
        for (int i = 0; i < 300; i++) send(8'($urandom), 1'($urandom));
        check("sat_drops", drop_cnt, 255);
        check("sat_ovf", overflow, 1);
        check("sat_count", count, 16);
        b0 = beats;
        drain();
        check("sat_beats", beats - b0, 17);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if (!qvld) begin
                din = 8'($urandom);
                dc  = 1'($urandom);
            end
            if ($urandom_range(0, 2) == 0) qvld = ~qvld;
            en      = ($urandom_range(0, 7) != 0);
            m_ready = 1'($urandom);
            clr     = ($urandom_range(0, 199) == 0);
            tick();
        end
        clr = 1'b0; en = 1'b1; qvld = 1'b0;
        tick();
        drain();

        // Reset mid-stream discards buffered words
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(8'(8'hC0 + i), 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("midrst_count", count, 0);
        check("midrst_valid", m_valid, 0);
        check("end_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
